// File: rtl/xsim_ctrl_pkg.sv
// Shared types and exit codes for the simulation finish handshake.
// State encoding is visible on the top-level state port, so the values are fixed.
package xsim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GRACE = 2'd2,
    DONE  = 2'd3
  } finish_state_t;

  localparam logic [7:0] FIN_CLEAN   = 8'h00;
  localparam logic [7:0] FIN_TIMEOUT = 8'h01;
  localparam logic [7:0] FIN_ABORT   = 8'h02;
  localparam int         FIN_ERR_BIT = 7;

  // Timer width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_updown_ctr.sv
// Saturating up/down counter of in-flight transactions with a sticky error flag
// raised on underflow (dec at zero) or overflow (inc at the maximum value).
module sat_updown_ctr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  localparam logic [W-1:0] MAX = '1;

  // Simultaneous inc and dec cancel and cannot produce an error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (count == MAX) err <= 1'b1;
          else              count <= count + W'(1);
        end
        2'b01: begin
          if (count == '0) err <= 1'b1;
          else             count <= count - W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xsim_finish_ctrl.sv
// Design-side finish handshake: drains outstanding transactions, waits a quiet
// grace period, then raises a sticky finish level with an exit code.
module xsim_finish_ctrl
  import xsim_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned GRACE_CYCLES = 16,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             finish_req,
  input  logic             abort_req,
  input  logic             txn_start,
  input  logic             txn_done,
  output logic [CNT_W-1:0] outstanding,
  output logic [CYC_W-1:0] cycles,
  output logic [1:0]       state,
  output logic             finish,
  output logic [7:0]       finish_code
);

  localparam int unsigned TO_W = timer_width(TIMEOUT);
  localparam int unsigned GR_W = timer_width(GRACE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRACE_CYCLES - 1);

  finish_state_t   state_q;
  logic [TO_W-1:0] to_timer;
  logic [GR_W-1:0] gr_timer;
  logic [6:0]      code_q;
  logic            finish_q;
  logic [CYC_W-1:0] cyc_q;
  logic            ctr_err;

  sat_updown_ctr #(.W(CNT_W)) u_ctr (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (txn_start),
    .dec   (txn_done),
    .count (outstanding),
    .err   (ctr_err)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) cyc_q <= '0;
    else        cyc_q <= cyc_q + CYC_W'(1);
  end

  // Priority in DRAIN/GRACE: abort, then timeout, then drain/grace progress.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      to_timer <= '0;
      gr_timer <= '0;
      code_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (abort_req) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            code_q   <= FIN_ABORT[6:0];
          end else if (finish_req) begin
            state_q  <= DRAIN;
            to_timer <= '0;
          end
        end
        DRAIN: begin
          if (abort_req) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            code_q   <= FIN_ABORT[6:0];
          end else if (to_timer == TO_LAST) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            code_q   <= FIN_TIMEOUT[6:0];
          end else begin
            to_timer <= to_timer + TO_W'(1);
            if (outstanding == '0 && !txn_start) begin
              state_q  <= GRACE;
              gr_timer <= '0;
            end
          end
        end
        GRACE: begin
          if (abort_req) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            code_q   <= FIN_ABORT[6:0];
          end else if (to_timer == TO_LAST) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
            code_q   <= FIN_TIMEOUT[6:0];
          end else begin
            // The timeout budget spans re-entries into DRAIN; only grace restarts.
            to_timer <= to_timer + TO_W'(1);
            if (txn_start) begin
              state_q <= DRAIN;
            end else if (gr_timer == GR_LAST) begin
              state_q  <= DONE;
              finish_q <= 1'b1;
              code_q   <= FIN_CLEAN[6:0];
            end else begin
              gr_timer <= gr_timer + GR_W'(1);
            end
          end
        end
        DONE: ;
      endcase
    end
  end

  assign state       = state_q;
  assign finish      = finish_q;
  assign cycles      = cyc_q;
  assign finish_code = {ctr_err, code_q};

endmodule

// File: tb/tb_xsim_finish_ctrl.sv
// Directed and randomized checks of the finish handshake against a small
// transaction/cycle model and timing expectations derived from the handshake rules.
module tb_xsim_finish_ctrl;

  localparam int CNT_W = 8;
  localparam int CYC_W = 32;
  localparam int GRACE = 16;
  localparam int TMO   = 1024;

  localparam int S_IDLE  = 0;
  localparam int S_DRAIN = 1;
  localparam int S_GRACE = 2;
  localparam int S_DONE  = 3;

  logic             CLK;
  logic             RST_N;
  logic             finish_req;
  logic             abort_req;
  logic             txn_start;
  logic             txn_done;
  logic [CNT_W-1:0] outstanding;
  logic [CYC_W-1:0] cycles;
  logic [1:0]       state;
  logic             finish;
  logic [7:0]       finish_code;

  int          n_cmp;
  int          n_bad;
  int          m_out;
  bit          m_err;
  logic [31:0] m_cyc;

  xsim_finish_ctrl #(
    .CNT_W(CNT_W), .CYC_W(CYC_W), .GRACE_CYCLES(GRACE), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .finish_req(finish_req), .abort_req(abort_req),
    .txn_start(txn_start), .txn_done(txn_done), .outstanding(outstanding),
    .cycles(cycles), .state(state), .finish(finish), .finish_code(finish_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given single-cycle inputs; model and counters checked after the edge.
  task automatic step(input logic fr, input logic ab, input logic ts, input logic td);
    finish_req = fr; abort_req = ab; txn_start = ts; txn_done = td;
    @(posedge CLK); #1;
    m_cyc = m_cyc + 32'd1;
    if (ts && !td) begin
      if (m_out == (1 << CNT_W) - 1) m_err = 1'b1;
      else m_out = m_out + 1;
    end else if (td && !ts) begin
      if (m_out == 0) m_err = 1'b1;
      else m_out = m_out - 1;
    end
    finish_req = 1'b0; abort_req = 1'b0; txn_start = 1'b0; txn_done = 1'b0;
    check("outstanding", 32'(outstanding), 32'(m_out));
    check("cycles", cycles, m_cyc);
    check("err_bit", 32'(finish_code[7]), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One reset edge with random inputs that must be ignored.
  task automatic rst_step();
    RST_N = 1'b0;
    finish_req = 1'($urandom); abort_req = 1'($urandom);
    txn_start = 1'($urandom); txn_done = 1'($urandom);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    finish_req = 1'b0; abort_req = 1'b0; txn_start = 1'b0; txn_done = 1'b0;
    m_out = 0; m_err = 1'b0; m_cyc = '0;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_state", 32'(state), S_IDLE);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_code", 32'(finish_code), 32'd0);
  endtask

  task automatic expect_state(input string tag, input int st, input logic fin, input logic [7:0] code);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_finish"}, 32'(finish), 32'(fin));
    if (fin) check({tag, "_code"}, 32'(finish_code), 32'(code));
  endtask

  initial begin
    int n;
    n_cmp = 0; n_bad = 0;
    m_out = 0; m_err = 1'b0; m_cyc = '0;
    RST_N = 1'b0;
    finish_req = 1'b0; abort_req = 1'b0; txn_start = 1'b0; txn_done = 1'b0;

    // Reset then 50 idle cycles.
    rst_step(); rst_step();
    idle(50);
    check("idle50_cycles", cycles, 32'd50);
    expect_state("idle50", S_IDLE, 1'b0, 8'h00);

    // Three transactions drained, then a full grace period.
    rst_step();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_state("drain_entry", S_DRAIN, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      idle(4);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("drain_hold", S_DRAIN, 1'b0, 8'h00);
    end
    idle(1);
    expect_state("grace_entry", S_GRACE, 1'b0, 8'h00);
    idle(GRACE - 1);
    expect_state("grace_last", S_GRACE, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_state("clean_done", S_DONE, 1'b1, 8'h00);
    idle(5);
    expect_state("done_sticky", S_DONE, 1'b1, 8'h00);

    // A start at grace count 10 restarts the drain and a full grace.
    rst_step();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    expect_state("g2_entry", S_GRACE, 1'b0, 8'h00);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_state("g2_back", S_DRAIN, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_state("g2_drain", S_DRAIN, 1'b0, 8'h00);
    idle(1);
    expect_state("g2_regrace", S_GRACE, 1'b0, 8'h00);
    idle(GRACE - 1);
    expect_state("g2_notyet", S_GRACE, 1'b0, 8'h00);
    idle(1);
    expect_state("g2_done", S_DONE, 1'b1, 8'h00);

    // A transaction that never retires forces a timeout.
    rst_step();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(TMO - 1);
    expect_state("tmo_before", S_DRAIN, 1'b0, 8'h00);
    idle(1);
    expect_state("tmo_done", S_DONE, 1'b1, 8'h01);

    // Abort beats finish_req in IDLE; a later underflow sets the error bit.
    rst_step();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_state("abort", S_DONE, 1'b1, 8'h02);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_state("abort_err", S_DONE, 1'b1, 8'h82);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    expect_state("done_ignores", S_DONE, 1'b1, 8'h82);

    // Reset in mid-drain, then a clean 1+GRACE finish.
    rst_step();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    expect_state("mid_drain", S_DRAIN, 1'b0, 8'h00);
    rst_step();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(GRACE);
    expect_state("post_rst_notyet", S_GRACE, 1'b0, 8'h00);
    idle(1);
    expect_state("post_rst_done", S_DONE, 1'b1, 8'h00);

    // Random transaction traffic against the counter model.
    rst_step();
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    check("rand_code", 32'(finish_code), m_err ? 32'h80 : 32'h00);

    // Saturation at the top of the count.
    rst_step();
    for (int i = 0; i < (1 << CNT_W); i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_count", 32'(outstanding), 32'd255);
    check("sat_code", 32'(finish_code), 32'h80);

    // Abort at a random moment, with random traffic before it.
    for (int r = 0; r < 4; r++) begin
      rst_step();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++)
        step(1'($urandom_range(0, 3) == 0), 1'b0, 1'($urandom), 1'($urandom));
      step(1'b0, 1'b1, 1'b0, 1'b0);
      expect_state("rand_abort", S_DONE, 1'b1, m_err ? 8'h82 : 8'h02);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
